// File: rtl/cache_mem_pkg.sv
// Shared constants and types for the cached data memory timing model.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_mem_pkg;

  localparam int MEM_WORDS_DEF    = 64;
  localparam int CACHE_LINES_DEF  = 4;
  localparam int MISS_LATENCY_DEF = 3;

  localparam int WORD_IDX_W = $clog2(MEM_WORDS_DEF);
  localparam int LINE_IDX_W = $clog2(CACHE_LINES_DEF);
  localparam int TAG_W      = WORD_IDX_W - LINE_IDX_W;

  localparam logic [31:0] MEM_INIT_BASE = 32'hD000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  // Reset contents of backing word i: base pattern tagged with its byte address.
  function automatic logic [31:0] mem_init_word(input int i);
    return MEM_INIT_BASE | (32'(i) << 2);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Direct-mapped tag/valid array: combinational hit lookup, single-line fill port.
// Latency: hit is combinational; a fill is visible from the next cycle.
// Backpressure: none, fill is accepted whenever fill_en is high; rst_i clears all lines.
module cache_tag_store #(
  parameter int LINE_W = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] lookup_line,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  input  logic              fill_en,
  input  logic [LINE_W-1:0] fill_line,
  input  logic [TAG_W-1:0]  fill_tag
);

  localparam int LINES = 1 << LINE_W;

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];

  // Lines are invalidated on reset; a fill simply overwrites the previous owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (fill_en) begin
      valid_q[fill_line] <= 1'b1;
      tag_q[fill_line]   <= fill_tag;
    end
  end

  // Hit only when the line is valid and owned by the requested tag.
  always_comb begin
    hit = valid_q[lookup_line] && (tag_q[lookup_line] == lookup_tag);
  end

endmodule

// File: rtl/cached_data_memory.sv
// OBI-style data memory with a tag-only direct-mapped cache timing model.
// Latency: hit granted same cycle, miss granted MISS_LATENCY+1 cycles after req; rvalid one cycle after gnt.
// Backpressure: gnt withheld while a miss is being modelled; requester holds req/addr/we/be/wdata until gnt.
module cached_data_memory
  import cache_mem_pkg::*;
#(
  parameter int MEM_WORDS    = MEM_WORDS_DEF,
  parameter int CACHE_LINES  = CACHE_LINES_DEF,
  parameter int MISS_LATENCY = MISS_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(CACHE_LINES);
  localparam int TW = AW - LW;
  localparam int CW = $clog2(MISS_LATENCY + 1);

  // Address decode: upper bits alias, byte offset ignored.
  logic [AW-1:0] word_idx;
  logic [LW-1:0] line_idx;
  logic [TW-1:0] tag;
  logic          unused_addr_bits;

  assign word_idx         = data_addr_i[AW+1:2];
  assign line_idx         = word_idx[LW-1:0];
  assign tag              = word_idx[AW-1:LW];
  assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};

  logic [31:0] mem [MEM_WORDS];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] miss_line_q;
  logic [TW-1:0] miss_tag_q;
  logic          hit;
  logic          gnt_c;
  logic          grant;
  logic          miss_start;
  logic          fill_en;
  logic          rvalid_q;
  logic [31:0]   rdata_q;

  cache_tag_store #(
    .LINE_W (LW),
    .TAG_W  (TW)
  ) u_tags (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_line (line_idx),
    .lookup_tag  (tag),
    .hit         (hit),
    .fill_en     (fill_en),
    .fill_line   (miss_line_q),
    .fill_tag    (miss_tag_q)
  );

  // Next-state: grant hits immediately, otherwise count down the miss penalty then fill.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_c      = 1'b0;
    miss_start = 1'b0;
    fill_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (hit) begin
            gnt_c = 1'b1;
          end else begin
            miss_start = 1'b1;
            cnt_d      = CW'(MISS_LATENCY - 1);
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (cnt_q == '0) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset cycle must never accept a request.
  assign grant = gnt_c & ~rst_i;

  // FSM registers; the missing line/tag are latched so the fill completes even if req drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_line_q <= '0;
      miss_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (miss_start) begin
        miss_line_q <= line_idx;
        miss_tag_q  <= tag;
      end
    end
  end

  // Backing array: reinitialised on reset, byte-enabled write-through on granted stores.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= mem_init_word(i);
      end
    end else if (grant && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response register: one rvalid per grant, data only for loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= grant;
      rdata_q  <= (grant && !data_we_i) ? mem[word_idx] : 32'h0;
    end
  end

  assign data_gnt_o    = grant;
  assign data_rvalid_o = rvalid_q & ~rst_i;
  assign data_rdata_o  = data_rvalid_o ? rdata_q : 32'h0;
  assign data_err_o    = 1'b0;

endmodule

// File: tb/tb_cached_data_memory.sv
// Bench: table vectors, hand sequences for back-to-back and reset-mid-miss, randomized accesses vs. a reference model.
// Two identical instances are driven in lockstep and compared every sampled cycle.
module tb_cached_data_memory;

  localparam int MISS_STALL = 4;
  localparam int TIMEOUT    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt_a, rvalid_a, err_a;
  logic [31:0] rdata_a;
  logic        gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cached_data_memory dut_a (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt_a),
    .data_rvalid_o(rvalid_a), .data_rdata_o(rdata_a), .data_err_o(err_a)
  );

  cached_data_memory dut_b (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt_b),
    .data_rvalid_o(rvalid_b), .data_rdata_o(rdata_b), .data_err_o(err_b)
  );

  // Reference model: plain arrays following the memory/cache rules.
  logic [31:0] mem_m   [64];
  logic        valid_m [4];
  logic [3:0]  tag_m   [4];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic twin(input string name);
    chk({name, "_twin_gnt"}, {31'h0, gnt_b}, {31'h0, gnt_a});
    chk({name, "_twin_rvalid"}, {31'h0, rvalid_b}, {31'h0, rvalid_a});
    chk({name, "_twin_rdata"}, rdata_b, rdata_a);
    chk({name, "_err"}, {31'h0, err_a | err_b}, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem_m[i] = 32'hD000_0000 + 32'(i * 4);
    for (int i = 0; i < 4; i++) begin
      valid_m[i] = 1'b0;
      tag_m[i]   = 4'h0;
    end
  endtask

  task automatic model_access(input logic w_en, input logic [3:0] b_en, input logic [31:0] a,
                              input logic [31:0] wd, output int stall, output logic [31:0] rd);
    int w, l, t;
    w = int'((a >> 2) % 64);
    l = w % 4;
    t = w / 4;
    stall = (valid_m[l] && tag_m[l] == 4'(t)) ? 0 : MISS_STALL;
    valid_m[l] = 1'b1;
    tag_m[l]   = 4'(t);
    rd = 32'h0;
    if (w_en) begin
      for (int b = 0; b < 4; b++)
        if (b_en[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rd = mem_m[w];
    end
  endtask

  // Request already driven for cycle 0; count stall cycles, then check the response beat.
  task automatic wait_grant(input string name, input int exp_stall, input logic [31:0] exp_rd);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= TIMEOUT) begin
      @(negedge clk);
      twin(name);
      chk({name, "_rv_pre"}, {31'h0, rvalid_a}, 32'h0);
      chk({name, "_rd_pre"}, rdata_a, 32'h0);
      if (gnt_a) begin
        got = 1'b1;
      end else begin
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    chk({name, "_stall"}, 32'(cyc), 32'(exp_stall));
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    twin(name);
    chk({name, "_rvalid"}, {31'h0, rvalid_a}, 32'h1);
    chk({name, "_rdata"}, rdata_a, exp_rd);
  endtask

  task automatic do_access(input string name, input logic w_en, input logic [3:0] b_en,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_stall, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    req = 1'b1; we = w_en; be = b_en; addr = a; wdata = wd;
    wait_grant(name, exp_stall, exp_rd);
  endtask

  // Reset with a request pending: nothing may be granted or returned while rst is high.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h10; wdata = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", {31'h0, gnt_a}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid_a}, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    twin("rst");
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    model_reset();
  endtask

  initial begin
    int          stall;
    logic [31:0] rd, a;
    logic        w_en;

    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

    //         we    be      addr           wdata          stall       rdata
    vecs[0]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         MISS_STALL, 32'hD000_0010};
    vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         0,          32'hD000_0010};
    vecs[2]  = '{1'b1, 4'h3, 32'h0000_0010, 32'hAAAA_BBBB, 0,          32'h0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         0,          32'hD000_BBBB};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         MISS_STALL, 32'hD000_0020};
    vecs[5]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         MISS_STALL, 32'hD000_BBBB};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         MISS_STALL, 32'hD000_0020};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_0110, 32'h0,         MISS_STALL, 32'hD000_BBBB};
    vecs[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         0,          32'hD000_BBBB};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_00FC, 32'h1234_5678, MISS_STALL, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 32'h0000_00FC, 32'h0,         0,          32'h1234_5678};
    vecs[11] = '{1'b1, 4'h8, 32'h0000_0014, 32'hAB00_0000, MISS_STALL, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         0,          32'hAB00_0014};
    vecs[13] = '{1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 0,          32'h0};
    vecs[14] = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,         0,          32'hAB00_0014};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].be, vecs[i].addr,
                vecs[i].wdata, vecs[i].stall, vecs[i].rdata);
    end

    // Back-to-back hits: second grant coincides with the first rvalid.
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h10;
    @(negedge clk);
    twin("b2b0");
    chk("b2b_gnt0", {31'h0, gnt_a}, 32'h1);
    chk("b2b_rv_early", {31'h0, rvalid_a}, 32'h0);
    @(posedge clk);
    #1;
    addr = 32'hFC;
    @(negedge clk);
    twin("b2b1");
    chk("b2b_gnt1", {31'h0, gnt_a}, 32'h1);
    chk("b2b_rv0", {31'h0, rvalid_a}, 32'h1);
    chk("b2b_rd0", rdata_a, 32'hD000_BBBB);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("b2b_rv1", {31'h0, rvalid_a}, 32'h1);
    chk("b2b_rd1", rdata_a, 32'h1234_5678);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_rv_done", {31'h0, rvalid_a}, 32'h0);
    chk("b2b_rd_done", rdata_a, 32'h0);

    // Randomized traffic against the reference model, with aliasing upper bits and idle gaps.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 11)) << 2)
          | 32'($urandom_range(0, 3));
      w_en = ($urandom_range(0, 2) == 0);
      be = 4'($urandom_range(0, 15));
      wdata = $urandom;
      model_access(w_en, be, a, wdata, stall, rd);
      do_access($sformatf("rnd%0d", n), w_en, be, a, wdata, stall, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset during the miss of a load to 0x30: no response, and the load misses again afterwards.
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h30;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rmiss_gnt_pre", {31'h0, gnt_a}, 32'h0);
      twin("rmiss_pre");
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rmiss_gnt_rst", {31'h0, gnt_a}, 32'h0);
    chk("rmiss_rv_rst", {31'h0, rvalid_a}, 32'h0);
    twin("rmiss_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wait_grant("rmiss", MISS_STALL, 32'hD000_0030);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
